lut_rw_seq: RTL and testbench
=============================

Name: lut_rw_seq

Overview:
- Parametrised, writable successor to the fixed constant lookup table used by the datapath.
- Synchronous RAM-backed LUT with a self-initialising sweep, one registered read port with a valid handshake, and one write port for runtime reprogramming.
- Sits beside the register file and feeds constant or offset values to the ALU and branch-target logic.

Parameters:
- DEPTH, 32, number of entries.
- DATA_W, 8, entry width in bits.
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).
- INIT_BASE, 60, value loaded into entry 0 by the init sweep.
- INIT_COUNT, 14, number of entries loaded with INIT_BASE+i; entries INIT_COUNT..DEPTH-1 are loaded with 0.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- reinit  in  1  one-cycle pulse that restarts the init sweep
- init_busy  out  1  high while the sweep runs
- rd_req  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_ready  out  1  read accepted when rd_req && rd_ready at an edge
- rd_valid  out  1  one-cycle pulse; rd_data is valid
- rd_data  out  DATA_W  read result
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data

Behaviour:
- Reset (reset_n=0 at an edge): state=INIT, idx=0, init_busy=1, rd_valid=0, rd_data=0. Memory contents are left undefined until the sweep rewrites them.
- State machine:
  - INIT: each edge writes mem[idx] = (idx<INIT_COUNT) ? (INIT_BASE+idx) mod 2^DATA_W : 0, then increments idx. On the edge that writes DEPTH-1, the FSM moves to RUN and clears init_busy.
  - init_busy is therefore high for exactly DEPTH cycles after reset release.
  - RUN: normal operation. reinit=1 moves to INIT with idx=0.
  - reinit during INIT restarts the sweep at idx=0.
- rd_ready = (state==RUN) && !reinit, purely combinational.
- Read:
  - An accepted request at edge N gives rd_valid=1 and rd_data=mem[rd_addr] after edge N, i.e. 1-cycle latency.
  - Back-to-back accepts give a continuous rd_valid stream.
  - Without an accept, rd_valid=0 and rd_data holds its last value.
- Write: wr_en at an edge in RUN updates mem[wr_addr]. wr_en is ignored in INIT and on reinit cycles.
- Same-edge read and write to the same address: rd_data returns the OLD contents (read-before-write), unless LUT_FWD_EN is defined.
- Address ≥ DEPTH (non-power-of-two DEPTH only): a read returns 0 with rd_valid still pulsed; a write is dropped.
- Reset mid-operation: any pending read result is discarded (rd_valid=0 next cycle) and the sweep restarts.
- Arithmetic: INIT_BASE+idx is computed at DATA_W width and wraps modulo 2^DATA_W.

Optional Feature:
- Macro LUT_FWD_EN.
- Defined: a same-edge write and accepted read to the same address return wr_data on rd_data (write-through forwarding).
- Undefined: the old contents are returned.
- No other behaviour changes.

Decomposition:
- Package lut_pkg holds:
  - lut_state_t enum {INIT, RUN}
  - LUT_DEFAULT_DEPTH=32, LUT_DEFAULT_DATA_W=8, LUT_DEFAULT_BASE=60, LUT_DEFAULT_COUNT=14
- Sub-module lut_storage_ram: single write port, single synchronous read port, DEPTH×DATA_W, no reset. Init FSM, handshake and forwarding mux live in the top.

Test Plan:
- Release reset -> init_busy=1 and rd_ready=0 for exactly 32 cycles; rd_req held high during that time -> no rd_valid.
- After init, read addr 0, 13, 14, 31 -> rd_data 60, 73, 0, 0, each with a one-cycle rd_valid on the cycle after accept; back-to-back reads -> 4 consecutive rd_valid cycles.
- Write addr 5 = 0xAA, then read 5 -> 0xAA; write addr 31 = 0xFF, read -> 0xFF.
- Same edge: write addr 7 = 0x11 and read addr 7 -> rd_data 67 (LUT_FWD_EN undefined) or 0x11 (defined); next read of 7 -> 0x11 in both builds.
- After writing addr 5 = 0xAA, pulse reinit -> init_busy high 32 cycles and wr_en ignored meanwhile; then read 5 -> 65. INIT_BASE=250 build: read 10 -> 4 (wrap).
- Assert reset_n=0 on the cycle after a read accept -> rd_valid=0 and rd_data=0 next cycle; sweep restarts.

Source files
------------

// File: rtl/lut_rw_seq_pkg.sv
// Shared types and default sizing for the writable lookup table.
package lut_pkg;

   typedef enum logic [0:0] {
      INIT,
      RUN
   } lut_state_t;

   localparam int unsigned LUT_DEFAULT_DEPTH  = 32;
   localparam int unsigned LUT_DEFAULT_DATA_W = 8;
   localparam int unsigned LUT_DEFAULT_BASE   = 60;
   localparam int unsigned LUT_DEFAULT_COUNT  = 14;

endpackage

// File: rtl/lut_rw_seq_if.sv
// Read/write/control bundle between the datapath and the lookup table.
interface lut_rw_seq_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 8
);
   logic              reinit;
   logic              init_busy;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output reinit, rd_req, rd_addr, wr_en, wr_addr, wr_data,
      input  init_busy, rd_ready, rd_valid, rd_data
   );

   modport slave (
      input  reinit, rd_req, rd_addr, wr_en, wr_addr, wr_data,
      output init_busy, rd_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/lut_storage_ram.sv
// Plain DEPTH x DATA_W storage: one write port, one registered read port, no reset.
module lut_storage_ram #(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write and read share the edge; the read sees the pre-write contents.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/lut_rw_seq.sv
// Writable lookup table with a self-initialising sweep and a valid-handshaked read port.
// Optional build macro LUT_FWD_EN: a same-edge write and accepted read to one address
// returns the new write data instead of the old contents.
module lut_rw_seq
   import lut_pkg::*;
#(
   parameter  int unsigned DEPTH      = LUT_DEFAULT_DEPTH,
   parameter  int unsigned DATA_W     = LUT_DEFAULT_DATA_W,
   parameter  int unsigned INIT_BASE  = LUT_DEFAULT_BASE,
   parameter  int unsigned INIT_COUNT = LUT_DEFAULT_COUNT,
   localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
   input logic         clk,
   input logic         reset_n,
   lut_rw_seq_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

   lut_state_t        r_state, w_state_d;
   logic [ADDR_W-1:0] r_idx, w_idx_d;

   logic              w_rd_accept;
   logic              w_rd_in_range;
   logic              w_wr_in_range;
   logic              w_fwd_hit;
   logic [DATA_W-1:0] w_init_val;

   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_waddr;
   logic [DATA_W-1:0] w_ram_wdata;
   logic [DATA_W-1:0] w_ram_q;

   logic              r_rd_valid;
   logic              r_sel_zero;
   logic              r_sel_fwd;
   logic [DATA_W-1:0] r_fwd_data;

   // Out-of-range addresses only exist when DEPTH is not a power of two.
   assign w_rd_in_range = {1'b0, bus.rd_addr} < DEPTH_L;
   assign w_wr_in_range = {1'b0, bus.wr_addr} < DEPTH_L;

   assign bus.rd_ready  = (r_state == RUN) && !bus.reinit;
   assign bus.init_busy = (r_state == INIT);
   assign w_rd_accept   = bus.rd_req && bus.rd_ready;

   // Sweep value wraps at DATA_W bits.
   assign w_init_val = (32'(r_idx) < INIT_COUNT) ? DATA_W'(INIT_BASE + 32'(r_idx)) : '0;

   // State and sweep index register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= INIT;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_d;
         r_idx   <= w_idx_d;
      end
   end

   // Next-state: sweep every entry once, then serve until reinit.
   always_comb begin
      w_state_d = r_state;
      w_idx_d   = r_idx;
      unique case (r_state)
         INIT: begin
            if (bus.reinit) begin
               w_idx_d = '0;
            end else if (r_idx == LAST_IDX) begin
               w_state_d = RUN;
               w_idx_d   = '0;
            end else begin
               w_idx_d = r_idx + ADDR_W'(1);
            end
         end
         RUN: begin
            if (bus.reinit) begin
               w_state_d = INIT;
               w_idx_d   = '0;
            end
         end
      endcase
   end

   // Write port mux: sweep owns the RAM in INIT, user writes only in RUN.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_waddr = bus.wr_addr;
      w_ram_wdata = bus.wr_data;
      if (r_state == INIT) begin
         w_ram_we    = 1'b1;
         w_ram_waddr = r_idx;
         w_ram_wdata = w_init_val;
      end else if (bus.wr_en && !bus.reinit && w_wr_in_range) begin
         w_ram_we = 1'b1;
      end
   end

`ifdef LUT_FWD_EN
   assign w_fwd_hit = w_rd_accept && w_ram_we && (bus.wr_addr == bus.rd_addr);
`else
   assign w_fwd_hit = 1'b0;
`endif

   lut_storage_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk   (clk),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_waddr),
      .i_wdata (w_ram_wdata),
      .i_re    (w_rd_accept && w_rd_in_range),
      .i_raddr (bus.rd_addr),
      .o_rdata (w_ram_q)
   );

   // Read result selectors; the RAM output itself holds between accepts.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rd_valid <= 1'b0;
         r_sel_zero <= 1'b1;
         r_sel_fwd  <= 1'b0;
         r_fwd_data <= '0;
      end else begin
         r_rd_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_sel_zero <= !w_rd_in_range;
            r_sel_fwd  <= w_fwd_hit;
            r_fwd_data <= bus.wr_data;
         end
      end
   end

   assign bus.rd_valid = r_rd_valid;
   assign bus.rd_data  = r_sel_zero ? '0 : (r_sel_fwd ? r_fwd_data : w_ram_q);

endmodule

// File: tb/tb_lut_rw_seq.sv
// Self-checking bench for lut_rw_seq: spec vector table, hand-written corner sequences
// and randomised traffic against a memory-array reference model.
module tb_lut_rw_seq;
   import lut_pkg::*;

   localparam int unsigned DEPTH      = 32;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned ADDR_W     = 5;
   localparam int unsigned INIT_BASE  = 60;
   localparam int unsigned INIT_COUNT = 14;

`ifdef LUT_FWD_EN
   localparam logic [7:0] SAME_EDGE_EXP = 8'h11;
`else
   localparam logic [7:0] SAME_EDGE_EXP = 8'd67;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   lut_rw_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   lut_rw_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_w ();

   lut_rw_seq #(
      .DEPTH      (DEPTH),
      .DATA_W     (DATA_W),
      .INIT_BASE  (INIT_BASE),
      .INIT_COUNT (INIT_COUNT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   lut_rw_seq #(
      .DEPTH      (DEPTH),
      .DATA_W     (DATA_W),
      .INIT_BASE  (250),
      .INIT_COUNT (INIT_COUNT)
   ) dut_w (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_w)
   );

   int errs   = 0;
   int checks = 0;

   // Reference model: contents, remaining busy edges, last read result.
   logic [7:0] m_mem [DEPTH];
   int         m_busy_left;
   logic       m_valid;
   logic [7:0] m_data;

   typedef struct {
      logic       ri;
      logic       rq;
      logic [4:0] ra;
      logic       we;
      logic [4:0] wa;
      logic [7:0] wd;
      logic       ev;
      logic [7:0] ed;
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] img(input int i, input int base);
      return (i < int'(INIT_COUNT)) ? 8'((base + i) % 256) : 8'd0;
   endfunction

   task automatic model_load();
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = img(i, int'(INIT_BASE));
   endtask

   task automatic drive(input logic ri, input logic rq, input logic [4:0] ra,
                        input logic we, input logic [4:0] wa, input logic [7:0] wd);
      bus.reinit  = ri;
      bus.rd_req  = rq;
      bus.rd_addr = ra;
      bus.wr_en   = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
   endtask

   task automatic idle_w();
      bus_w.reinit  = 1'b0;
      bus_w.rd_req  = 1'b0;
      bus_w.rd_addr = '0;
      bus_w.wr_en   = 1'b0;
      bus_w.wr_addr = '0;
      bus_w.wr_data = '0;
   endtask

   // One clock with reset released; called at posedge+1.
   task automatic cycle(input logic ri, input logic rq, input logic [4:0] ra,
                        input logic we, input logic [4:0] wa, input logic [7:0] wd);
      logic exp_ready;
      logic acc;
      logic run;
      drive(ri, rq, ra, we, wa, wd);
      #1;
      exp_ready = (m_busy_left == 0) && !ri;
      chk("rd_ready", 32'(bus.rd_ready), 32'(exp_ready));
      acc = rq && exp_ready;
      run = (m_busy_left == 0);
      @(posedge clk);
      #1;
      if (acc) begin
         m_valid = 1'b1;
         m_data  = m_mem[ra];
`ifdef LUT_FWD_EN
         if (we && (wa == ra)) m_data = wd;
`endif
      end else begin
         m_valid = 1'b0;
      end
      if (run && !ri && we) m_mem[wa] = wd;
      if (ri) begin
         m_busy_left = int'(DEPTH);
         model_load();
      end else if (m_busy_left > 0) begin
         m_busy_left--;
      end
      chk("init_busy", 32'(bus.init_busy), 32'(m_busy_left > 0));
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
      chk("rd_data", 32'(bus.rd_data), 32'(m_data));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 8'd0);
      idle_w();
      @(posedge clk);
      #1;
      m_busy_left = int'(DEPTH);
      m_valid     = 1'b0;
      m_data      = 8'd0;
      model_load();
      chk("reset_busy", 32'(bus.init_busy), 32'd1);
      chk("reset_valid", 32'(bus.rd_valid), 32'd0);
      chk("reset_data", 32'(bus.rd_data), 32'd0);
      reset_n = 1'b1;
   endtask

   // Counts cycles init_busy stays high, with reads requested and a write attempted.
   task automatic wait_sweep(input string name);
      int n;
      int vcnt;
      n    = bus.init_busy ? 1 : 0;
      vcnt = 0;
      for (int k = 0; k < 40; k++) begin
         cycle(1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 8'h55);
         if (bus.rd_valid) vcnt++;
         if (!bus.init_busy) break;
         n++;
      end
      chk({name, "_busy_cycles"}, 32'(n), DEPTH);
      chk({name, "_valid_during_init"}, 32'(vcnt), 32'd0);
   endtask

   function automatic vec_t mk(input logic rq, input logic [4:0] ra, input logic we,
                               input logic [4:0] wa, input logic [7:0] wd,
                               input logic ev, input logic [7:0] ed);
      vec_t v;
      v.ri = 1'b0; v.rq = rq; v.ra = ra; v.we = we; v.wa = wa; v.wd = wd;
      v.ev = ev;   v.ed = ed;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vt[0]  = mk(1'b1, 5'd0,  1'b0, 5'd0,  8'h00, 1'b1, 8'd60);
      vt[1]  = mk(1'b1, 5'd13, 1'b0, 5'd0,  8'h00, 1'b1, 8'd73);
      vt[2]  = mk(1'b1, 5'd14, 1'b0, 5'd0,  8'h00, 1'b1, 8'd0);
      vt[3]  = mk(1'b1, 5'd31, 1'b0, 5'd0,  8'h00, 1'b1, 8'd0);
      vt[4]  = mk(1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 1'b0, 8'd0);
      vt[5]  = mk(1'b0, 5'd0,  1'b1, 5'd5,  8'hAA, 1'b0, 8'd0);
      vt[6]  = mk(1'b1, 5'd5,  1'b0, 5'd0,  8'h00, 1'b1, 8'hAA);
      vt[7]  = mk(1'b0, 5'd0,  1'b1, 5'd31, 8'hFF, 1'b0, 8'hAA);
      vt[8]  = mk(1'b1, 5'd31, 1'b0, 5'd0,  8'h00, 1'b1, 8'hFF);
      vt[9]  = mk(1'b1, 5'd7,  1'b1, 5'd7,  8'h11, 1'b1, SAME_EDGE_EXP);
      vt[10] = mk(1'b1, 5'd7,  1'b0, 5'd0,  8'h00, 1'b1, 8'h11);
      vt[11] = mk(1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 1'b0, 8'h11);

      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 8'd0);
      idle_w();
      @(posedge clk);
      #1;
      do_reset();
      wait_sweep("startup");

      // Spec vectors.
      for (int i = 0; i < 12; i++) begin
         cycle(vt[i].ri, vt[i].rq, vt[i].ra, vt[i].we, vt[i].wa, vt[i].wd);
         chk($sformatf("vec%0d_valid", i), 32'(bus.rd_valid), 32'(vt[i].ev));
         chk($sformatf("vec%0d_data", i), 32'(bus.rd_data), 32'(vt[i].ed));
      end

      // Wrap-around sweep values on the INIT_BASE=250 instance.
      bus_w.rd_req  = 1'b1;
      bus_w.rd_addr = 5'd10;
      cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 8'd0);
      chk("wrap_valid", 32'(bus_w.rd_valid), 32'd1);
      chk("wrap_addr10", 32'(bus_w.rd_data), 32'd4);
      bus_w.rd_addr = 5'd14;
      cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 8'd0);
      chk("wrap_addr14", 32'(bus_w.rd_data), 32'd0);
      idle_w();

      // Reinit restores the init image, writes ignored meanwhile.
      cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 8'hAA);
      cycle(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 8'h33);
      chk("reinit_no_accept", 32'(bus.rd_valid), 32'd0);
      wait_sweep("reinit");
      cycle(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 8'd0);
      chk("reinit_read5", 32'(bus.rd_data), 32'd65);

      // Reset right after an accept discards the pending result.
      cycle(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 8'd0);
      do_reset();
      wait_sweep("midreset");

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic ri;
         logic [4:0] ra;
         logic [4:0] wa;
         ri = ($urandom_range(0, 59) == 0);
         ra = 5'($urandom_range(0, 31));
         wa = ($urandom_range(0, 1) == 0) ? ra : 5'($urandom_range(0, 31));
         cycle(ri, 1'($urandom), ra, 1'($urandom), wa, 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
